// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// ALUOp codes from main control, R-type funct codes, result-select codes and
// the decoded-operation record produced by alu_funct_decode.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_EXEC    = 2'b01,
    S_SLT_SUB = 2'b10,
    S_SLT_SET = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_OR   = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_LESS = 2'b11
  } sel_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    sel_t sel;
    logic bnegate;
    logic is_slt;
    logic illegal;
  } op_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle between main control / ALU datapath and the sequencer.
//   req_valid/req_ready : request handshake (alu_op, funct qualify it)
//   sum_msb, ovf        : adder feedback from the ALU
//   sel1/sel0, ainvert, bnegate, less_set : ALU slice controls
//   capture, illegal    : one-cycle completion strobes
// slave  = sequencer side, master = control/datapath side.
interface alu_op_sequencer_if #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               sum_msb;
  logic               ovf;
  logic               sel1;
  logic               sel0;
  logic               ainvert;
  logic               bnegate;
  logic               less_set;
  logic               capture;
  logic               illegal;

  modport slave (
    input  req_valid, alu_op, funct, sum_msb, ovf,
    output req_ready, sel1, sel0, ainvert, bnegate, less_set, capture, illegal
  );

  modport master (
    output req_valid, alu_op, funct, sum_msb, ovf,
    input  req_ready, sel1, sel0, ainvert, bnegate, less_set, capture, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_funct_decode.sv
// Purely combinational decode of {alu_op, funct} into result select,
// bnegate, an SLT flag and an illegal flag.
//   alu_op : ALUOp from main control
//   funct  : R-type funct field
//   op     : decoded operation record
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output op_t                op
);

  always_comb begin
    op = '{sel: SEL_AND, bnegate: 1'b0, is_slt: 1'b0, illegal: 1'b1};
    if (alu_op == ALUOP_W'(ALUOP_ADD)) begin
      op = '{sel: SEL_SUM, bnegate: 1'b0, is_slt: 1'b0, illegal: 1'b0};
    end else if (alu_op == ALUOP_W'(ALUOP_SUB)) begin
      op = '{sel: SEL_SUM, bnegate: 1'b1, is_slt: 1'b0, illegal: 1'b0};
    end else if (alu_op == ALUOP_W'(ALUOP_RTYPE)) begin
      if (funct == FUNCT_W'(FUNCT_ADD))
        op = '{sel: SEL_SUM, bnegate: 1'b0, is_slt: 1'b0, illegal: 1'b0};
      else if (funct == FUNCT_W'(FUNCT_SUB))
        op = '{sel: SEL_SUM, bnegate: 1'b1, is_slt: 1'b0, illegal: 1'b0};
      else if (funct == FUNCT_W'(FUNCT_AND))
        op = '{sel: SEL_AND, bnegate: 1'b0, is_slt: 1'b0, illegal: 1'b0};
      else if (funct == FUNCT_W'(FUNCT_OR))
        op = '{sel: SEL_OR, bnegate: 1'b0, is_slt: 1'b0, illegal: 1'b0};
      else if (funct == FUNCT_W'(FUNCT_SLT))
        op = '{sel: SEL_LESS, bnegate: 1'b1, is_slt: 1'b1, illegal: 1'b0};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one ALU request through valid/ready,
// decodes it into ALU slice controls and strobes capture when the result is
// valid. SLT runs a subtract pass, latches the sign-corrected set bit, then
// routes it onto bit 0's less input.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of alu_op_sequencer_if
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 2
) (
  input logic                clk,
  input logic                rst_n,
  alu_op_sequencer_if.slave  bus
);

  state_t state_q, state_d;
  op_t    dec_op;
  sel_t   op_sel_q;
  logic   op_bneg_q;
  logic   op_ill_q;
  logic   set_q;
  logic   accept;

  alu_funct_decode #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W)) u_decode (
    .alu_op (bus.alu_op),
    .funct  (bus.funct),
    .op     (dec_op)
  );

  assign accept = bus.req_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_sel_q  <= SEL_AND;
      op_bneg_q <= 1'b0;
      op_ill_q  <= 1'b0;
      set_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_sel_q  <= dec_op.sel;
        op_bneg_q <= dec_op.bnegate;
        op_ill_q  <= dec_op.illegal;
      end
      // Signed less-than from the subtract pass: sign bit corrected for overflow.
      if (state_q == S_SLT_SUB)
        set_q <= bus.sum_msb ^ bus.ovf;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.sel1      = 1'b0;
    bus.sel0      = 1'b0;
    bus.ainvert   = 1'b0;
    bus.bnegate   = 1'b0;
    bus.less_set  = 1'b0;
    bus.capture   = 1'b0;
    bus.illegal   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_d = dec_op.is_slt ? S_SLT_SUB : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (op_ill_q) begin
          bus.illegal = 1'b1;
        end else begin
          {bus.sel1, bus.sel0} = op_sel_q;
          bus.bnegate          = op_bneg_q;
          bus.capture          = 1'b1;
        end
      end
      S_SLT_SUB: begin
        state_d              = S_SLT_SET;
        {bus.sel1, bus.sel0} = SEL_SUM;
        bus.bnegate          = 1'b1;
      end
      S_SLT_SET: begin
        state_d              = S_IDLE;
        {bus.sel1, bus.sel0} = SEL_LESS;
        bus.bnegate          = 1'b1;
        bus.less_set         = set_q;
        bus.capture          = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.FUNCT_W(6), .ALUOP_W(2)) bus ();

  alu_op_sequencer #(.FUNCT_W(6), .ALUOP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {req_ready, sel1, sel0, ainvert, bnegate, less_set, capture, illegal}
  function automatic logic [7:0] outs();
    return {bus.req_ready, bus.sel1, bus.sel0, bus.ainvert,
            bus.bnegate, bus.less_set, bus.capture, bus.illegal};
  endfunction

  function automatic logic [7:0] pk(input logic rdy, input logic [1:0] sel,
                                    input logic bneg, input logic less,
                                    input logic cap, input logic ill);
    return {rdy, sel, 1'b0, bneg, less, cap, ill};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the operation table.
  task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                            output logic [1:0] sel, output logic bneg,
                            output logic slt, output logic ill);
    sel = 2'b00; bneg = 1'b0; slt = 1'b0; ill = 1'b0;
    if (op == 2'b00) sel = 2'b10;
    else if (op == 2'b01) begin sel = 2'b10; bneg = 1'b1; end
    else if (op == 2'b10) begin
      case (f)
        6'b100000: sel = 2'b10;
        6'b100010: begin sel = 2'b10; bneg = 1'b1; end
        6'b100100: sel = 2'b00;
        6'b100101: sel = 2'b01;
        6'b101010: slt = 1'b1;
        default:   ill = 1'b1;
      endcase
    end else ill = 1'b1;
  endtask

  // Runs one request from IDLE; a,b are the operands the ALU would subtract.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  sel;
    logic        bneg, slt, ill, msb, ov, less;
    logic [31:0] diff;
    ref_decode(op, f, sel, bneg, slt, ill);
    diff = a - b;
    msb  = diff[31];
    ov   = (a[31] != b[31]) && (diff[31] != a[31]);
    less = $signed(a) < $signed(b);
    check({tag, ":pre"}, outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.req_valid = 1'b1; bus.alu_op = op; bus.funct = f;
    bus.sum_msb = 1'($urandom); bus.ovf = 1'($urandom);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.alu_op = 2'($urandom); bus.funct = 6'($urandom);
    if (slt) begin
      bus.sum_msb = msb; bus.ovf = ov;
      check({tag, ":sub"}, outs(), pk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      bus.sum_msb = ~msb; bus.ovf = 1'($urandom);
      check({tag, ":set"}, outs(), pk(1'b0, 2'b11, 1'b1, less, 1'b1, 1'b0));
    end else if (ill) begin
      check({tag, ":ill"}, outs(), pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      check({tag, ":exec"}, outs(), pk(1'b0, sel, bneg, 1'b0, 1'b1, 1'b0));
    end
    @(posedge clk); #1;
    check({tag, ":post"}, outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

  initial begin
    logic [1:0]  b2b_op [3];
    logic [5:0]  b2b_f  [3];
    int          acc_t  [3];
    int          cap_t  [3];
    int          t, idx, ncap;
    logic        exp_cap;
    logic [1:0]  rop;
    logic [5:0]  rf;

    bus.req_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'b0;
    bus.sum_msb = 1'b0; bus.ovf = 1'b0;
    rst_n = 1'b0;
    #2;
    check("reset_async", outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.req_valid = 1'b1; bus.alu_op = 2'b00;
    @(posedge clk); #1;
    check("reset_held", outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("and",      2'b10, 6'b100100, 32'd1, 32'd2);
    run_op("beq_sub",  2'b01, 6'($urandom), 32'd9, 32'd4);
    run_op("lw_add",   2'b00, 6'($urandom), 32'd9, 32'd4);
    run_op("slt_3_5",  2'b10, 6'b101010, 32'd3, 32'd5);
    run_op("slt_5_3",  2'b10, 6'b101010, 32'd5, 32'd3);
    run_op("slt_ovf1", 2'b10, 6'b101010, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_op("slt_ovf2", 2'b10, 6'b101010, 32'h8000_0000, 32'h0000_0001);
    run_op("bad_fn",   2'b10, 6'b100111, 32'd0, 32'd0);
    run_op("rsvd_op",  2'b11, 6'b100000, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = (rop == 2'b10) ? functs[$urandom_range(0, 5)] : 6'($urandom);
      run_op("rand", rop, rf, $urandom, $urandom);
    end

    // Back-to-back with req_valid held: add, slt, or.
    b2b_op = '{2'b10, 2'b10, 2'b10};
    b2b_f  = '{6'b100000, 6'b101010, 6'b100101};
    t = 0;
    for (int i = 0; i < 3; i++) begin
      acc_t[i] = t;
      cap_t[i] = (b2b_f[i] == 6'b101010) ? t + 2 : t + 1;
      t        = (b2b_f[i] == 6'b101010) ? t + 3 : t + 2;
    end
    idx  = 0;
    ncap = 0;
    bus.sum_msb = 1'b1; bus.ovf = 1'b0;
    bus.req_valid = 1'b1; bus.alu_op = b2b_op[0]; bus.funct = b2b_f[0];
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      exp_cap = 1'b0;
      for (int i = 0; i < 3; i++) if (cap_t[i] == e + 1) exp_cap = 1'b1;
      check($sformatf("b2b_cap_c%0d", e + 1), {7'b0, bus.capture}, {7'b0, exp_cap});
      if (bus.capture) ncap++;
      if (idx < 3 && acc_t[idx] == e) begin
        idx++;
        if (idx < 3) begin
          bus.alu_op = b2b_op[idx]; bus.funct = b2b_f[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 8'(ncap), 8'd3);

    // Reset during SLT_SUB discards the in-flight slt.
    bus.req_valid = 1'b1; bus.alu_op = 2'b10; bus.funct = 6'b101010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_sub", outs(), pk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check("mid_rst", outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("mid_rst_hold", outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", outs(), pk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    run_op("after_rst", 2'b10, 6'b100101, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
